// File: rtl/i2s_receiver_pkg.sv
// ---------------------------------------------------------------------------
// i2s_receiver_pkg : shared types for the I2S receive path       rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package i2s_receiver_pkg;

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    RECV = 1'b1
  } i2s_state_t;

  localparam logic I2S_CH_LEFT  = 1'b0;
  localparam logic I2S_CH_RIGHT = 1'b1;

endpackage

`default_nettype wire

// File: rtl/i2s_receiver_sync_edge_det.sv
// ---------------------------------------------------------------------------
// sync_edge_det : N-stage synchronizer with registered level and rise strobe
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sync_edge_det #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic in,
  output logic out,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              lvl_q;
  logic              rise_q;

  // out is delayed one stage so that every instance presents its level
  // aligned with the rise strobe of the sclk instance.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync_q <= '0;
      lvl_q  <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], in};
      lvl_q  <= sync_q[STAGES-1];
      rise_q <= sync_q[STAGES-1] & ~lvl_q;
    end
  end

  assign out  = lvl_q;
  assign rise = rise_q;

endmodule

`default_nettype wire

// File: rtl/i2s_receiver.sv
// ---------------------------------------------------------------------------
// i2s_receiver : oversampled I2S / left-justified stereo deserialiser
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module i2s_receiver
  import i2s_receiver_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int DELAY = 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    sclk,
  input  logic                    lrclk,
  input  logic                    sd,
  output logic signed [WIDTH-1:0] left_data,
  output logic signed [WIDTH-1:0] right_data,
  output logic                    valid,
  output logic                    frame_error
);

  localparam int DW = DELAY + WIDTH;
  localparam int CW = $clog2(DW + 1);

  logic srise, lr_s, sd_s;
  logic w_unused_sclk_lvl, w_unused_lr_rise, w_unused_sd_rise;

  sync_edge_det #(.STAGES(2)) u_sync_sclk (
    .clk(clk), .rstn(rstn), .in(sclk), .out(w_unused_sclk_lvl), .rise(srise));
  sync_edge_det #(.STAGES(2)) u_sync_lr (
    .clk(clk), .rstn(rstn), .in(lrclk), .out(lr_s), .rise(w_unused_lr_rise));
  sync_edge_det #(.STAGES(2)) u_sync_sd (
    .clk(clk), .rstn(rstn), .in(sd), .out(sd_s), .rise(w_unused_sd_rise));

  i2s_state_t       state_q, state_d;
  logic             ch_q, ch_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             pend_q, pend_d;
  logic             lr_prev_q, lr_prev_d;
  logic             lr_vld_q, lr_vld_d;
  logic             pair_q, pair_d;
  logic             ferr_q, ferr_d;
  logic [WIDTH-1:0] left_q, right_q;
  logic             valid_q;

  logic [CW-1:0]    c;
  logic [WIDTH-1:0] sr;
  logic             chv, bound, run;

  // Pass 0 lets the old channel take the boundary bit (DELAY>0); pass 1
  // counts the boundary srise as position 0 of the new channel.
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    hold_d    = hold_q;
    pend_d    = pend_q;
    lr_prev_d = lr_prev_q;
    lr_vld_d  = lr_vld_q;
    pair_d    = 1'b0;
    ferr_d    = 1'b0;
    c         = cnt_q;
    sr        = sr_q;
    chv       = ch_q;
    bound     = 1'b0;
    run       = 1'b0;
    if (srise) begin
      lr_prev_d = lr_s;
      lr_vld_d  = 1'b1;
      bound     = lr_vld_q && (lr_s != lr_prev_q);
      for (int p = 0; p < 2; p++) begin
        if (p == 1 && bound) begin
          if (state_q == RECV && c < CW'(DW)) begin
            ferr_d = 1'b1;
            pend_d = 1'b0;
          end
          state_d = RECV;
          c       = '0;
          chv     = lr_s;
        end
        if (p == 0) run = (state_q == RECV) && (DELAY > 0);
        else        run = (state_d == RECV) && (bound || DELAY == 0);
        if (run && c < CW'(DW)) begin
          if (c + CW'(1) > CW'(DELAY)) sr = {sr[WIDTH-2:0], sd_s};
          c = c + CW'(1);
          if (c == CW'(DW)) begin
            if (chv == I2S_CH_LEFT) begin
              hold_d = sr;
              pend_d = 1'b1;
            end else if (pend_d) begin
              pair_d = 1'b1;
              pend_d = 1'b0;
            end
          end
        end
      end
      ch_d  = chv;
      cnt_d = c;
      sr_d  = sr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= HUNT;
      ch_q      <= I2S_CH_LEFT;
      cnt_q     <= '0;
      sr_q      <= '0;
      hold_q    <= '0;
      pend_q    <= 1'b0;
      lr_prev_q <= 1'b0;
      lr_vld_q  <= 1'b0;
      pair_q    <= 1'b0;
      ferr_q    <= 1'b0;
      left_q    <= '0;
      right_q   <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      hold_q    <= hold_d;
      pend_q    <= pend_d;
      lr_prev_q <= lr_prev_d;
      lr_vld_q  <= lr_vld_d;
      pair_q    <= pair_d;
      ferr_q    <= ferr_d;
      valid_q   <= pair_q;
      // sr_q still holds the right word here: srises are >=4 cycles apart.
      if (pair_q) begin
        left_q  <= hold_q;
        right_q <= sr_q;
      end
    end
  end

  assign left_data   = left_q;
  assign right_data  = right_q;
  assign valid       = valid_q;
  assign frame_error = ferr_q;

endmodule

`default_nettype wire

// File: tb/tb_i2s_receiver.sv
// ---------------------------------------------------------------------------
// tb_i2s_receiver : scoreboard bench for i2s_receiver (I2S and LJ)  rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_i2s_receiver;
  import i2s_receiver_pkg::*;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic sclk0 = 1'b0, lr0 = 1'b0, sd0 = 1'b0;
  logic sclk1 = 1'b0, lr1 = 1'b0, sd1 = 1'b0;
  logic [23:0] l0, r0, l1, r1;
  logic v0, fe0, v1, fe1;

  always #5 clk = ~clk;

  i2s_receiver #(.WIDTH(24), .DELAY(1)) dut_i2s (
    .clk(clk), .rstn(rstn), .sclk(sclk0), .lrclk(lr0), .sd(sd0),
    .left_data(l0), .right_data(r0), .valid(v0), .frame_error(fe0));

  i2s_receiver #(.WIDTH(24), .DELAY(0)) dut_lj (
    .clk(clk), .rstn(rstn), .sclk(sclk1), .lrclk(lr1), .sd(sd1),
    .left_data(l1), .right_data(r1), .valid(v1), .frame_error(fe1));

  typedef struct {
    bit          err;
    logic [23:0] l;
    logic [23:0] r;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  bit          s_lr[$];
  bit          s_sd[$];
  logic [23:0] hl[2];
  logic [23:0] hr[2];
  int          nchk = 0;
  int          nfail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    nchk++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic mon_step(input int id, input logic v, input logic fe,
                          input logic [23:0] l, input logic [23:0] r);
    exp_t e;
    if (v || fe) begin
      if ((id == 0 ? q0.size() : q1.size()) == 0) begin
        chk(id == 0 ? "i2s_unexpected_event" : "lj_unexpected_event", {62'd0, v, fe}, 64'd0);
      end else begin
        e = (id == 0) ? q0.pop_front() : q1.pop_front();
        chk(id == 0 ? "i2s_event" : "lj_event",
            {14'd0, v, fe, v ? {l, r} : 48'd0},
            e.err ? {14'd0, 2'b01, 48'd0} : {14'd0, 2'b10, e.l, e.r});
      end
    end else begin
      chk(id == 0 ? "i2s_hold" : "lj_hold", {16'd0, l, r}, {16'd0, hl[id], hr[id]});
    end
    if (v) begin
      hl[id] = l;
      hr[id] = r;
    end
  endtask

  always @(negedge clk) begin
    if (!rstn) begin
      hl[0] = '0; hr[0] = '0; hl[1] = '0; hr[1] = '0;
    end else begin
      mon_step(0, v0, fe0, l0, r0);
      mon_step(1, v1, fe1, l1, r1);
    end
  end

  task automatic add_slot(input bit ch, input logic [23:0] w, input int nbits, input int slot);
    for (int k = 0; k < slot; k++) begin
      s_lr.push_back(ch);
      s_sd.push_back(k < nbits ? w[23-k] : 1'b0);
    end
  endtask

  task automatic frame(input logic [23:0] l, input logic [23:0] r, input int slot);
    add_slot(I2S_CH_LEFT, l, 24, slot);
    add_slot(I2S_CH_RIGHT, r, 24, slot);
  endtask

  task automatic expv(input int id, input logic [23:0] l, input logic [23:0] r);
    exp_t e;
    e.err = 1'b0; e.l = l; e.r = r;
    if (id == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic expe(input int id);
    exp_t e;
    e.err = 1'b1; e.l = '0; e.r = '0;
    if (id == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic lat_check();
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1 chk("lj_latency_early", {63'd0, v1}, 64'd0);
    @(posedge clk);
    #1 chk("lj_latency_on", {63'd0, v1}, 64'd1);
  endtask

  // One sclk period = 8 clk; edges sit 3 time units off the clk edges.
  task automatic play(input int tgt, input int dly, input int mark);
    logic b;
    @(posedge clk);
    #3;
    for (int i = 0; i < s_lr.size(); i++) begin
      b = (i >= dly) ? s_sd[i-dly] : 1'b0;
      if (tgt == 0) begin sclk0 = 1'b0; lr0 = s_lr[i]; sd0 = b; end
      else          begin sclk1 = 1'b0; lr1 = s_lr[i]; sd1 = b; end
      #40;
      if (tgt == 0) sclk0 = 1'b1; else sclk1 = 1'b1;
      if (i == mark) fork lat_check(); join_none
      #40;
    end
    sclk0 = 1'b0;
    sclk1 = 1'b0;
    s_lr.delete();
    s_sd.delete();
    repeat (8) @(posedge clk);
  endtask

  task automatic do_reset(input bit check);
    @(posedge clk);
    #2 rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    if (check) begin
      chk("rst_left", {40'd0, l0}, 64'd0);
      chk("rst_right", {40'd0, r0}, 64'd0);
      chk("rst_valid", {63'd0, v0}, 64'd0);
      chk("rst_ferr", {63'd0, fe0}, 64'd0);
    end
    #1 rstn = 1'b1;
  endtask

  initial begin
    do_reset(1'b1);

    // nominal I2S frame, preceded by a dummy right half for alignment
    add_slot(I2S_CH_RIGHT, 24'h0, 24, 24);
    frame(24'h123456, 24'h800001, 24);
    add_slot(I2S_CH_LEFT, 24'h0, 0, 4);
    expv(0, 24'h123456, 24'h800001);
    play(0, 1, -1);

    // back-to-back frames
    do_reset(1'b0);
    add_slot(I2S_CH_RIGHT, 24'h0, 24, 24);
    frame(24'h000001, 24'hFFFFFF, 24);
    frame(24'h7FFFFF, 24'h800000, 24);
    frame(24'h000000, 24'h000000, 24);
    add_slot(I2S_CH_LEFT, 24'h0, 0, 4);
    expv(0, 24'h000001, 24'hFFFFFF);
    expv(0, 24'h7FFFFF, 24'h800000);
    expv(0, 24'h000000, 24'h000000);
    play(0, 1, -1);

    // 32-slot padding
    do_reset(1'b0);
    add_slot(I2S_CH_RIGHT, 24'h0, 0, 32);
    frame(24'hABCDEF, 24'h654321, 32);
    add_slot(I2S_CH_LEFT, 24'h0, 0, 4);
    expv(0, 24'hABCDEF, 24'h654321);
    play(0, 1, -1);

    // short left channel (20 bits)
    do_reset(1'b0);
    add_slot(I2S_CH_RIGHT, 24'h0, 24, 24);
    add_slot(I2S_CH_LEFT, 24'hFEDCBA, 20, 20);
    add_slot(I2S_CH_RIGHT, 24'h13579B, 24, 24);
    frame(24'h2468AC, 24'h0F0F0F, 24);
    add_slot(I2S_CH_LEFT, 24'h0, 0, 4);
    expe(0);
    expv(0, 24'h2468AC, 24'h0F0F0F);
    play(0, 1, -1);

    // reset halfway through a right word
    do_reset(1'b0);
    add_slot(I2S_CH_RIGHT, 24'h0, 24, 24);
    frame(24'h111111, 24'h222222, 24);
    add_slot(I2S_CH_LEFT, 24'h333333, 24, 24);
    add_slot(I2S_CH_RIGHT, 24'h444444, 12, 12);
    expv(0, 24'h111111, 24'h222222);
    play(0, 1, -1);
    do_reset(1'b1);
    add_slot(I2S_CH_RIGHT, 24'h555555, 24, 24);
    frame(24'h666666, 24'h777777, 24);
    add_slot(I2S_CH_LEFT, 24'h0, 0, 4);
    expv(0, 24'h666666, 24'h777777);
    play(0, 1, -1);

    // left-justified; period 71 carries the right LSB
    do_reset(1'b0);
    add_slot(I2S_CH_RIGHT, 24'h0, 24, 24);
    frame(24'h000ABC, 24'hFFF000, 24);
    add_slot(I2S_CH_LEFT, 24'h0, 0, 4);
    expv(1, 24'h000ABC, 24'hFFF000);
    play(1, 0, 71);

    repeat (50) @(posedge clk);
    chk("i2s_drain", 64'(q0.size()), 64'd0);
    chk("lj_drain", 64'(q1.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule

`default_nettype wire
